// File: rtl/watch_pkg.sv
// watch_pkg: shared widths, state encoding and correction constant for the BCD/binary converters.
package watch_pkg;
    localparam int DIGITS = 3;
    localparam int BIN_W = 10;
    localparam int DIGIT_W = 4;
    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [DIGIT_W-1:0] CORR = 4'd3;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble digit correction, subtracts 3 when the digit is 8 or more.
module bcd_digit_adj
    import watch_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);
    always_comb q = (d >= 4'd8) ? d - CORR : d;
endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential 3-digit BCD-to-binary converter, one result bit per clock.
// Define BCD_CHECK_EN to reject digits above 9 with err=1 and a zero result.
module bcd_to_bin
    import watch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t state_q, state_d;
    logic [BCD_W-1:0] bcd_sr_q, bcd_sr_d, shifted, adjusted;
    logic [BIN_W-1:0] bin_sr_q, bin_sr_d, bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic done_q, done_d, err_q, err_d, bad;

`ifdef BCD_CHECK_EN
    always_comb bad = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
`else
    always_comb bad = 1'b0;
`endif

    always_comb shifted = {1'b0, bcd_sr_q[BCD_W-1:1]};

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(shifted[i*DIGIT_W +: DIGIT_W]),
            .q(adjusted[i*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        bcd_sr_d = bcd_sr_q;
        bin_sr_d = bin_sr_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: if (start) begin
                bcd_sr_d = bad ? '0 : {hundreds, tens, ones};
                bin_sr_d = '0;
                cnt_d    = '0;
                err_d    = bad;
                state_d  = bad ? DONE : SHIFT;
            end
            SHIFT: begin
                bcd_sr_d = adjusted;
                bin_sr_d = {bcd_sr_q[0], bin_sr_q[BIN_W-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = (cnt_q == CNT_W'(BIN_W - 1)) ? DONE : SHIFT;
            end
            DONE: begin
                bin_d   = bin_sr_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bcd_sr_q <= '0;
            bin_sr_q <= '0;
            cnt_q    <= '0;
            bin_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            bin_sr_q <= bin_sr_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bin  = bin_q;
    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: table, directed and random checks of bcd_to_bin against decimal arithmetic.
module tb_bcd_to_bin;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [3:0] hundreds = '0, tens = '0, ones = '0;
    logic [9:0] bin;
    logic busy, done, err;
    int checks = 0;
    int failures = 0;

    bcd_to_bin dut (
        .clk(clk), .rst(rst), .start(start),
        .hundreds(hundreds), .tens(tens), .ones(ones),
        .bin(bin), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] h, t, o;
        int exp;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Starts a conversion and waits for done; lat counts negedges after the start edge.
    task automatic run(input logic [3:0] h, t, o, output logic [9:0] b, output int lat, output int busyc);
        @(negedge clk);
        hundreds = h; tens = t; ones = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hundreds = 4'd7; tens = 4'd7; ones = 4'd7;
        lat = 0; busyc = 0;
        while (!done && lat < 40) begin
            busyc += int'(busy);
            @(negedge clk);
            lat++;
        end
        b = bin;
    endtask

    task automatic conv(input logic [3:0] h, t, o, input int exp);
        logic [9:0] b;
        int lat, busyc;
        run(h, t, o, b, lat, busyc);
        chk("bin", int'(b), exp);
        chk("latency", lat, 11);
        chk("busy_cycles", busyc, 10);
        chk("bcd_sr_zero", int'(dut.bcd_sr_q), 0);
        chk("err", int'(err), 0);
        @(negedge clk);
        chk("done_once", int'(done), 0);
    endtask

    initial begin
        logic [9:0] b;
        int lat, busyc, seen;
        vecs[0] = '{4'd0, 4'd0, 4'd0, 0};
        vecs[1] = '{4'd2, 4'd5, 4'd5, 255};
        vecs[2] = '{4'd0, 4'd5, 4'd9, 59};
        vecs[3] = '{4'd9, 4'd9, 4'd9, 999};
        vecs[4] = '{4'd1, 4'd0, 4'd0, 100};
        vecs[5] = '{4'd5, 4'd1, 4'd2, 512};
        vecs[6] = '{4'd0, 4'd0, 4'd1, 1};

        // Reset held with start asserted: nothing may begin.
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bin", int'(bin), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        for (int i = 0; i < 7; i++)
            conv(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].exp);

        // Starts pulsed during SHIFT and DONE are ignored.
        @(negedge clk);
        hundreds = 4'd3; tens = 4'd4; ones = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0;
        while (!done && lat < 40) begin
            start = (lat == 4 || lat == 10);
            hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("ignore_bin", int'(bin), 345);
        chk("ignore_lat", lat, 11);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            seen += int'(done);
        end
        chk("ignore_no_extra_done", seen, 0);

        // Reset mid-conversion aborts without done.
        @(negedge clk);
        hundreds = 4'd1; tens = 4'd2; ones = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_bin", int'(bin), 0);
        chk("abort_busy", int'(busy), 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            seen += int'(done);
        end
        chk("abort_no_done", seen, 0);
        conv(4'd1, 4'd2, 4'd8, 128);

`ifdef BCD_CHECK_EN
        run(4'd1, 4'hA, 4'd3, b, lat, busyc);
        chk("chk_bin", int'(b), 0);
        chk("chk_lat", lat, 1);
        chk("chk_err", int'(err), 1);
        @(negedge clk);
        chk("chk_err_hold", int'(err), 1);
        conv(4'd0, 4'd4, 4'd2, 42);
`endif

        for (int v = 0; v < 1000; v++)
            conv(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), v);

        repeat (200) begin
            logic [3:0] h, t, o;
            h = 4'($urandom_range(9));
            t = 4'($urandom_range(9));
            o = 4'($urandom_range(9));
            conv(h, t, o, 100 * int'(h) + 10 * int'(t) + int'(o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
